// File: rtl/regfile_writeback.sv
// Register file write-port producer: merges 1-cycle ALU results with buffered LSU results
// and tracks in-flight long-latency destinations for the decode hazard stall.
module regfile_writeback #(
    parameter  int XLEN       = 32,
    parameter  int NREG       = 32,
    parameter  int FIFO_DEPTH = 2,
    localparam int AW         = $clog2(NREG),
    localparam int PW         = $clog2(FIFO_DEPTH),
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic            issue_long,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            stall,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [CW-1:0]   fifo_count
);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          fifo_q [FIFO_DEPTH];
    entry_t          fifo_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic   alu_wr;
    logic   push;
    logic   pop;
    logic   set_pend;
    entry_t head;

    // Handshake and arbitration; ALU always wins, and x0 results never reach the port.
    always_comb begin
        lsu_ready = (count_q != CW'(FIFO_DEPTH));
        alu_wr    = alu_valid && (alu_rd != '0);
        push      = lsu_valid && lsu_ready && (lsu_rd != '0);
        pop       = !alu_wr && (count_q != '0);
        head      = fifo_q[rd_ptr_q];
    end

    always_comb begin
        stall = issue_valid &&
                (((rs1_addr != '0) && pending_q[rs1_addr]) ||
                 ((rs2_addr != '0) && pending_q[rs2_addr]) ||
                 ((issue_rd != '0) && pending_q[issue_rd]));
        set_pend = issue_valid && issue_long && (issue_rd != '0) && !stall;
    end

    // Pop reads the registered head, so an entry pushed this cycle is never popped with it.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q].rd   = lsu_rd;
            fifo_d[wr_ptr_q].data = lsu_data;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Set is applied after clear so a same-cycle set on the popped register survives.
    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            pending_d[head.rd] = 1'b0;
        end
        if (set_pend) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        rf_we_d    = alu_wr || pop;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (alu_wr) begin
            rf_waddr_d = alu_rd;
            rf_wdata_d = alu_data;
        end else if (pop) begin
            rf_waddr_d = head.rd;
            rf_wdata_d = head.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign fifo_count = count_q;

    // Decode must never let an ALU op target a register still owed by the LSU.
    a_no_alu_to_pending: assert property (@(posedge clk) disable iff (reset)
        !(alu_wr && pending_q[alu_rd]));
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(push && (count_q == CW'(FIFO_DEPTH))));
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count_q <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed vector table, a mid-operation reset sequence,
// then random traffic compared against a queue-based reference model.
module tb_regfile_writeback;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_long;
    logic [4:0]  issue_rd, rs1_addr, rs2_addr;
    logic        stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    regfile_writeback #(.XLEN(XLEN), .NREG(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .stall(stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv, il;
        logic [4:0]  ird, rs1, rs2;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        e_stall, e_ready;
        logic [1:0]  e_count;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic iv, il, input logic [4:0] ird, rs1, rs2,
                                 input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                 input logic es, er, input logic [1:0] ec,
                                 input logic ew, input logic [4:0] ea, input logic [31:0] ed);
        vec_t v;
        v.iv = iv; v.il = il; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
        v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.e_stall = es; v.e_ready = er; v.e_count = ec;
        v.e_we = ew; v.e_waddr = ea; v.e_wdata = ed;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        issue_valid = v.iv; issue_long = v.il; issue_rd = v.ird;
        rs1_addr = v.rs1; rs2_addr = v.rs2;
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
        lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of pending LSU results and a bit per register.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          mpend[32];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic modelReset();
        mq.delete();
        for (int r = 0; r < 32; r++) mpend[r] = 1'b0;
        m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    endtask

    function automatic bit modelStall();
        return issue_valid && ((rs1_addr != 0 && mpend[rs1_addr]) ||
                               (rs2_addr != 0 && mpend[rs2_addr]) ||
                               (issue_rd != 0 && mpend[issue_rd]));
    endfunction

    task automatic modelCheck(input int n);
        checkOutput($sformatf("rand%0d.stall", n), 32'(stall), 32'(modelStall()));
        checkOutput($sformatf("rand%0d.ready", n), 32'(lsu_ready), 32'(mq.size() < DEPTH));
        checkOutput($sformatf("rand%0d.count", n), 32'(fifo_count), 32'(mq.size()));
        checkOutput($sformatf("rand%0d.we", n), 32'(rf_we), 32'(m_we));
        checkOutput($sformatf("rand%0d.waddr", n), 32'(rf_waddr), 32'(m_waddr));
        checkOutput($sformatf("rand%0d.wdata", n), rf_wdata, m_wdata);
    endtask

    task automatic modelStep();
        bit   ready, st, aluw;
        ent_t e;
        ready = mq.size() < DEPTH;
        st    = modelStall();
        aluw  = alu_valid && alu_rd != 0;
        if (aluw) begin
            m_we = 1'b1; m_waddr = alu_rd; m_wdata = alu_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_waddr = e.rd; m_wdata = e.data;
            mpend[e.rd] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (lsu_valid && ready && lsu_rd != 0) begin
            e.rd = lsu_rd; e.data = lsu_data;
            mq.push_back(e);
        end
        if (issue_valid && issue_long && issue_rd != 0 && !st) mpend[issue_rd] = 1'b1;
    endtask

    initial begin
        vec_t idle;
        idle = mkv(0,0,0,0,0, 0,0,0, 0,0,0, 0,1,0,0,0,0);

        //        iv il ird rs1 rs2  av ard ad            lv lrd ld        st rdy cnt we wa wd
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   1,5,32'hDEADBEEF, 0,0,0,           0,1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,0,1,5,32'hDEADBEEF));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,0,0,0,0));
        vecs.push_back(mkv(1,1,7,0,0,   0,0,0,            0,0,0,           0,1,0,0,0,0));
        vecs.push_back(mkv(1,0,0,7,0,   0,0,0,            0,0,0,           1,1,0,0,0,0));
        vecs.push_back(mkv(1,0,0,7,0,   0,0,0,            1,7,32'h1234,    1,1,0,0,0,0));
        vecs.push_back(mkv(1,0,0,7,0,   0,0,0,            0,0,0,           1,1,1,0,0,0));
        vecs.push_back(mkv(1,0,0,7,0,   0,0,0,            0,0,0,           0,1,0,1,7,32'h1234));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   1,1,32'h11,       1,8,32'h88,      0,1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   1,2,32'h22,       0,0,0,           0,1,1,1,1,32'h11));
        vecs.push_back(mkv(0,0,0,0,0,   1,3,32'h33,       0,0,0,           0,1,1,1,2,32'h22));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,1,1,3,32'h33));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,0,1,8,32'h88));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   1,1,32'h1,        1,9,32'h99,      0,1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   1,2,32'h2,        1,10,32'hAA,     0,1,1,1,1,32'h1));
        vecs.push_back(mkv(0,0,0,0,0,   1,3,32'h3,        1,11,32'hBB,     0,0,2,1,2,32'h2));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            1,11,32'hBB,     0,0,2,1,3,32'h3));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            1,11,32'hBB,     0,1,1,1,9,32'h99));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,1,1,10,32'hAA));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,0,1,11,32'hBB));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   1,0,32'hFF,       1,12,32'hCC,     0,1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   1,0,32'hEE,       0,0,0,           0,1,1,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,0,1,12,32'hCC));
        vecs.push_back(mkv(1,1,0,0,0,   0,0,0,            0,0,0,           0,1,0,0,0,0));
        vecs.push_back(mkv(1,0,0,0,0,   0,0,0,            0,0,0,           0,1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            1,0,32'h55,      0,1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,0,0,0,0));
        vecs.push_back(mkv(1,1,13,0,0,  0,0,0,            0,0,0,           0,1,0,0,0,0));
        vecs.push_back(mkv(1,0,13,0,0,  0,0,0,            0,0,0,           1,1,0,0,0,0));
        vecs.push_back(mkv(1,1,13,0,0,  0,0,0,            0,0,0,           1,1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            1,13,32'hD,      0,1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,1,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,   0,0,0,            0,0,0,           0,1,0,1,13,32'hD));
        vecs.push_back(mkv(1,0,0,0,13,  0,0,0,            0,0,0,           0,1,0,0,0,0));
        vecs.push_back(mkv(1,1,14,0,0,  0,0,0,            0,0,0,           0,1,0,0,0,0));
        vecs.push_back(mkv(1,1,15,14,0, 0,0,0,            0,0,0,           1,1,0,0,0,0));
        vecs.push_back(mkv(1,0,0,15,0,  0,0,0,            1,14,32'hE,      0,1,0,0,0,0));
        vecs.push_back(mkv(1,0,0,14,0,  0,0,0,            0,0,0,           1,1,1,0,0,0));
        vecs.push_back(mkv(1,0,0,14,0,  0,0,0,            0,0,0,           0,1,0,1,14,32'hE));

        reset = 1'b1;
        applyStimulus(idle);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.we", 32'(rf_we), 0);
        checkOutput("reset.count", 32'(fifo_count), 0);
        checkOutput("reset.ready", 32'(lsu_ready), 1);
        checkOutput("reset.waddr", 32'(rf_waddr), 0);
        checkOutput("reset.wdata", rf_wdata, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d.stall", i), 32'(stall), 32'(vecs[i].e_stall));
            checkOutput($sformatf("vec%0d.ready", i), 32'(lsu_ready), 32'(vecs[i].e_ready));
            checkOutput($sformatf("vec%0d.count", i), 32'(fifo_count), 32'(vecs[i].e_count));
            checkOutput($sformatf("vec%0d.we", i), 32'(rf_we), 32'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                checkOutput($sformatf("vec%0d.waddr", i), 32'(rf_waddr), 32'(vecs[i].e_waddr));
                checkOutput($sformatf("vec%0d.wdata", i), rf_wdata, vecs[i].e_wdata);
            end
            @(posedge clk);
            #1;
        end

        // Mid-operation reset: x3/x4 pending and the FIFO full, then reset between edges.
        applyStimulus(mkv(1,1,3,0,0, 1,1,32'h1, 1,20,32'h20, 0,0,0,0,0,0));
        @(posedge clk); #1;
        applyStimulus(mkv(1,1,4,0,0, 1,2,32'h2, 1,21,32'h21, 0,0,0,0,0,0));
        @(posedge clk); #1;
        applyStimulus(mkv(1,0,0,3,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        #1;
        checkOutput("midrst.pre_stall", 32'(stall), 1);
        checkOutput("midrst.pre_count", 32'(fifo_count), 2);
        checkOutput("midrst.pre_ready", 32'(lsu_ready), 0);
        #1 reset = 1'b1;
        #1;
        checkOutput("midrst.we", 32'(rf_we), 0);
        checkOutput("midrst.count", 32'(fifo_count), 0);
        checkOutput("midrst.ready", 32'(lsu_ready), 1);
        checkOutput("midrst.waddr", 32'(rf_waddr), 0);
        checkOutput("midrst.stall", 32'(stall), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        modelReset();
        applyStimulus(mkv(1,0,0,3,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        #1;
        checkOutput("postrst.stall_rs1_3", 32'(stall), 0);
        applyStimulus(mkv(1,0,4,4,3, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        #1;
        checkOutput("postrst.stall_x4", 32'(stall), 0);
        applyStimulus(idle);
        @(posedge clk); #1;
        modelStep();

        for (int n = 0; n < 600; n++) begin
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_long  = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1_addr    = 5'($urandom_range(0, 7));
            rs2_addr    = 5'($urandom_range(0, 7));
            alu_valid   = ($urandom_range(0, 1) == 1);
            alu_rd      = 5'($urandom_range(0, 7));
            if (mpend[alu_rd]) alu_rd = 5'd0;
            alu_data    = $urandom;
            lsu_valid   = ($urandom_range(0, 4) < 2);
            lsu_rd      = 5'($urandom_range(0, 7));
            lsu_data    = $urandom;
            #1;
            modelCheck(n);
            modelStep();
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Producer side of the integer register file's single write port.
- Merges single-cycle ALU results with long-latency load/multiply (LSU) results into one registered write per cycle.
- LSU results are buffered in a small FIFO.
- A per-register pending scoreboard drives a decode stall for RAW and WAW hazards against in-flight long-latency ops.

Parameters:
- XLEN, 32, data width of write data.
- NREG, 32, number of architectural registers; address width is log2(NREG).
- FIFO_DEPTH, 2, LSU result buffer entries (power of two, at least 2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- issue_valid  in  1  decode issues an instruction this cycle
- issue_long  in  1  issued instruction completes via the LSU path
- issue_rd  in  5  destination of the issued instruction
- rs1_addr  in  5  decode source 1, for hazard check
- rs2_addr  in  5  decode source 2, for hazard check
- stall  out  1  decode must hold; combinational
- alu_valid  in  1  ALU result present; always accepted
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  LSU result accepted (= FIFO not full)
- lsu_rd  in  5  LSU destination
- lsu_data  in  XLEN  LSU result
- rf_we  out  1  register file write enable; registered
- rf_waddr  out  5  register file write address; registered
- rf_wdata  out  XLEN  register file write data; registered
- fifo_count  out  log2(FIFO_DEPTH)+1  LSU FIFO occupancy

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation):
  - pending[] all 0; FIFO emptied and contents discarded.
  - rf_we=0, rf_waddr=0, rf_wdata=0, fifo_count=0.
  - lsu_ready=1 once FIFO is empty.
- Write arbitration, evaluated each cycle, result registered at the posedge:
  - ALU write: alu_valid && alu_rd!=0. Next cycle rf_we=1, rf_waddr=alu_rd, rf_wdata=alu_data. ALU latency is 1 cycle.
  - If no ALU write and the FIFO is non-empty: pop the head. Next cycle rf_we=1, rf_waddr/rf_wdata from the head.
  - Otherwise rf_we=0 next cycle. rf_waddr/rf_wdata hold their previous values.
  - ALU has strict priority; the FIFO can starve indefinitely under continuous ALU writes.
  - alu_valid with alu_rd=0 is dropped and does not block a FIFO pop.
- LSU handshake:
  - Transfer occurs when lsu_valid && lsu_ready.
  - lsu_ready = (fifo_count != FIFO_DEPTH), from registered state only.
  - lsu_rd=0 transfers are accepted and discarded (not pushed).
  - A pushed entry cannot be popped in the same cycle; minimum LSU latency is 2 cycles from handshake to rf_we.
  - Push and pop in the same cycle: count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - lsu_valid while lsu_ready=0: no transfer. The producer holds its data.
- Scoreboard (pending[NREG], bit 0 hardwired 0):
  - Set: issue_valid && issue_long && issue_rd!=0 && !stall sets pending[issue_rd] at the posedge.
  - Clear: a FIFO pop to rf_* clears pending[head.rd] at the same posedge.
  - If set and clear hit the same register in the same cycle, set wins.
- Stall (combinational from registered pending):
  - stall = issue_valid && ((rs1_addr!=0 && pending[rs1_addr]) || (rs2_addr!=0 && pending[rs2_addr]) || (issue_rd!=0 && pending[issue_rd])).
  - stall deasserts the cycle after the clearing pop, i.e. the same cycle the value appears on rf_* and is visible through the register file's write bypass.
- Assertions:
  - No ALU write to a register whose pending bit is set.
  - No push when full.
  - fifo_count never exceeds FIFO_DEPTH.

Test Plan:
- ALU basic: alu_valid, alu_rd=5, alu_data=0xDEADBEEF at cycle N -> cycle N+1 rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; cycle N+2 rf_we=0.
- RAW stall: issue_long with issue_rd=7; next cycle rs1_addr=7 gives stall=1. LSU delivers rd=7 data=0x1234 at cycle M with no ALU traffic -> rf_we/waddr=7/wdata=0x1234 at M+2; stall=0 from M+2.
- Contention: LSU pushes rd=8 while alu_valid writes x1,x2,x3 on consecutive cycles -> rf_waddr sequence 1,2,3,8; fifo_count 1 until the pop.
- Full/back-pressure: FIFO_DEPTH=2 with ALU busy; push rd=9, then rd=10 -> lsu_ready=0 and fifo_count=2. Third LSU result rd=11 held. ALU stops -> writes 9,10,11 in order; lsu_ready reasserts the cycle after the first pop.
- x0 handling: alu_rd=0 gives rf_we=0 and a FIFO pop proceeds that cycle. issue_long with issue_rd=0 sets no pending bit; rs1_addr=0 never stalls. lsu_rd=0 is accepted, fifo_count unchanged.
- Reset mid-operation: pending bits 3 and 4 set, fifo_count=2; assert reset asynchronously -> immediately rf_we=0, fifo_count=0, lsu_ready=1. After release, stall=0 for rs1_addr=3.
